// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard controller for a 5-stage in-order pipeline.
// It computes the operand forwarding selects, load-use stalls, redirect
// flushes and memory-busy freezes. Control outputs are combinational in the
// current inputs and the registered State.
// The optional macro HAZARD_STAT_EN adds saturating 16-bit stall/flush
// statistics counters. When the macro is undefined, the counter ports are
// tied to zero.
module pipeline_hazard_ctrl (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        En,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic        Use_Rs,
  input  logic        Use_Rt,
  input  logic [4:0]  E_Rd,
  input  logic        E_Wreg,
  input  logic        E_Mem2reg,
  input  logic [4:0]  M_Rd,
  input  logic        M_Wreg,
  input  logic [1:0]  Pcsrc,
  input  logic        Mem_Busy,
  output logic        PC_En,
  output logic        IFID_En,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic [1:0]  State,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic ex_rs;
  logic ex_rt;
  logic mem_rs;
  logic mem_rt;
  logic redirect;
  logic load_use;
  logic stall_act;
  logic flush_act;

  assign State = state_q;

  // Detect dependences of the ID operands on the EX and MEM destinations.
  // Register 0 never produces a dependence.
  always_comb begin
    ex_rs    = E_Wreg && (E_Rd != 5'd0) && (E_Rd == Rs) && Use_Rs;
    ex_rt    = E_Wreg && (E_Rd != 5'd0) && (E_Rd == Rt) && Use_Rt;
    mem_rs   = M_Wreg && (M_Rd != 5'd0) && (M_Rd == Rs) && Use_Rs;
    mem_rt   = M_Wreg && (M_Rd != 5'd0) && (M_Rd == Rt) && Use_Rt;
    redirect = (Pcsrc != 2'b00);
    // No load-use detection in FLUSH, because ID holds a bubble.
    // No detection in STALL either, because the load has already moved on to MEM.
    load_use = E_Mem2reg && (ex_rs || ex_rt) &&
               (state_q != FLUSH) && (state_q != STALL);
    stall_act = Clrn && En && !Mem_Busy && !redirect && load_use;
    flush_act = Clrn && En && !Mem_Busy && redirect;
  end

  // Resolve the per-cycle priority: hold > freeze > redirect > load-use > normal.
  always_comb begin
    PC_En      = 1'b1;
    IFID_En    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    FwdA       = 2'b00;
    FwdB       = 2'b00;
    state_d    = RUN;
    if (!Clrn) begin
      state_d = RUN;
    end else begin
      // An EX result is forwarded only when it is not a load, which is still in flight.
      if (ex_rs && !E_Mem2reg)  FwdA = 2'b01;
      else if (mem_rs)          FwdA = 2'b10;
      if (ex_rt && !E_Mem2reg)  FwdB = 2'b01;
      else if (mem_rt)          FwdB = 2'b10;
      if (!En) begin
        PC_En   = 1'b0;
        IFID_En = 1'b0;
        state_d = state_q;
      end else if (Mem_Busy) begin
        PC_En   = 1'b0;
        IFID_En = 1'b0;
        state_d = FREEZE;
      end else if (redirect) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
        state_d    = FLUSH;
      end else if (load_use) begin
        PC_En      = 1'b0;
        IFID_En    = 1'b0;
        IDEX_Flush = 1'b1;
        state_d    = STALL;
      end else begin
        state_d = RUN;
      end
    end
  end

  // State register: advances only on enabled cycles.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= RUN;
    end else if (En) begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters. stall_act and flush_act already include En.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_act && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_act && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`else
  logic unused_act;

  // Statistics are disabled, so the ports are tied to zero.
  assign unused_act = stall_act ^ flush_act;
  assign Stall_Cnt  = 16'd0;
  assign Flush_Cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. A behavioural model classifies each cycle
// into one action (hold, freeze, redirect, stall or normal). The expected
// outputs are derived from that action, and every output is compared on each
// falling edge. Directed vectors carry hand-computed literal expectations.
module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        En = 1'b1;
  logic [4:0]  Rs = '0, Rt = '0, E_Rd = '0, M_Rd = '0;
  logic        Use_Rs = 1'b0, Use_Rt = 1'b0;
  logic        E_Wreg = 1'b0, E_Mem2reg = 1'b0, M_Wreg = 1'b0;
  logic [1:0]  Pcsrc = '0;
  logic        Mem_Busy = 1'b0;
  logic        PC_En, IFID_En, IFID_Flush, IDEX_Flush;
  logic [1:0]  FwdA, FwdB, State;
  logic [15:0] Stall_Cnt, Flush_Cnt;

  int checks = 0;
  int errors = 0;

  // Model state: controller state code and event counts.
  int m_state = 0;
  int m_sc = 0;
  int m_fc = 0;
  int m_act;

  localparam int A_HOLD = 0, A_FREEZE = 1, A_REDIR = 2, A_STALL = 3, A_NORM = 4;

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .Clrn(Clrn), .En(En), .Rs(Rs), .Rt(Rt),
    .Use_Rs(Use_Rs), .Use_Rt(Use_Rt), .E_Rd(E_Rd), .E_Wreg(E_Wreg),
    .E_Mem2reg(E_Mem2reg), .M_Rd(M_Rd), .M_Wreg(M_Wreg), .Pcsrc(Pcsrc),
    .Mem_Busy(Mem_Busy), .PC_En(PC_En), .IFID_En(IFID_En),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .FwdA(FwdA),
    .FwdB(FwdB), .State(State), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes_to(input logic w, input logic [4:0] rd,
                                   input logic [4:0] src, input logic use_src);
    return w && (rd != 0) && (rd == src) && use_src;
  endfunction

  function automatic int fwd_of(input logic [4:0] src, input logic use_src);
    if (writes_to(E_Wreg, E_Rd, src, use_src) && !E_Mem2reg) return 1;
    if (writes_to(M_Wreg, M_Rd, src, use_src)) return 2;
    return 0;
  endfunction

  function automatic int action_of(input int st);
    bit lu;
    lu = E_Mem2reg && (writes_to(E_Wreg, E_Rd, Rs, Use_Rs) || writes_to(E_Wreg, E_Rd, Rt, Use_Rt))
         && st != 1 && st != 2;
    if (!En) return A_HOLD;
    if (Mem_Busy) return A_FREEZE;
    if (Pcsrc != 0) return A_REDIR;
    if (lu) return A_STALL;
    return A_NORM;
  endfunction

  // Reference model update at each clock edge and on asynchronous reset.
  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      m_state <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      m_act = action_of(m_state);
      case (m_act)
        A_FREEZE: m_state <= 3;
        A_REDIR:  begin m_state <= 2; if (m_fc < 65535) m_fc <= m_fc + 1; end
        A_STALL:  begin m_state <= 1; if (m_sc < 65535) m_sc <= m_sc + 1; end
        A_NORM:   m_state <= 0;
        default:  m_state <= m_state;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    int a;
    logic e_pc, e_fi, e_fd;
    int e_fa, e_fb;
    a = action_of(m_state);
    if (!Clrn) begin
      e_pc = 1; e_fi = 0; e_fd = 0; e_fa = 0; e_fb = 0;
    end else begin
      e_pc = (a == A_REDIR || a == A_NORM);
      e_fi = (a == A_REDIR);
      e_fd = (a == A_REDIR || a == A_STALL);
      e_fa = fwd_of(Rs, Use_Rs);
      e_fb = fwd_of(Rt, Use_Rt);
    end
    chk("pc_en", PC_En, e_pc);
    chk("ifid_en", IFID_En, e_pc);
    chk("ifid_flush", IFID_Flush, e_fi);
    chk("idex_flush", IDEX_Flush, e_fd);
    chk("fwd_a", FwdA, e_fa);
    chk("fwd_b", FwdB, e_fb);
    chk("state", State, m_state);
`ifdef HAZARD_STAT_EN
    chk("stall_cnt", Stall_Cnt, m_sc);
    chk("flush_cnt", Flush_Cnt, m_fc);
`else
    chk("stall_cnt", Stall_Cnt, 0);
    chk("flush_cnt", Flush_Cnt, 0);
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear();
    Rs = 0; Rt = 0; Use_Rs = 0; Use_Rt = 0; E_Rd = 0; E_Wreg = 0; E_Mem2reg = 0;
    M_Rd = 0; M_Wreg = 0; Pcsrc = 0; Mem_Busy = 0; En = 1;
  endtask

  task automatic load_r8();
    clear(); E_Wreg = 1; E_Mem2reg = 1; E_Rd = 8; Rt = 8; Use_Rt = 1;
  endtask

  initial begin
    clear();
    Clrn = 0;
    step(2);
    chk("rst_state", State, 2'b00);
    chk("rst_pc_en", PC_En, 1'b1);
    Clrn = 1;
    step(1);

    // EX forwarding of a non-load result.
    clear(); E_Wreg = 1; E_Rd = 5; Rs = 5; Use_Rs = 1;
    #2 chk("fwd_ex_a", FwdA, 2'b01); chk("fwd_ex_pc", PC_En, 1'b1);
    step(1); chk("fwd_ex_state", State, 2'b00);

    // Load-use stall for exactly one cycle, followed by MEM forwarding.
    load_r8();
    #2 chk("lu_pc", PC_En, 1'b0); chk("lu_idex", IDEX_Flush, 1'b1); chk("lu_ifid", IFID_Flush, 1'b0);
    step(1); chk("lu_state", State, 2'b01);
    clear(); M_Wreg = 1; M_Rd = 8; Rt = 8; Use_Rt = 1;
    #2 chk("lu_fwd_b", FwdB, 2'b10); chk("lu_pc2", PC_En, 1'b1);
    step(1); chk("lu_state2", State, 2'b00);

    // A repeated match while in STALL does not stall again.
    load_r8(); step(1);
    M_Wreg = 1; M_Rd = 8;
    #2 chk("rep_pc", PC_En, 1'b1); chk("rep_fwd_b", FwdB, 2'b10);
    step(1); chk("rep_state", State, 2'b00);

    // EX has priority over MEM; the use bit gates forwarding.
    clear(); E_Wreg = 1; E_Rd = 3; M_Wreg = 1; M_Rd = 3; Rs = 3; Use_Rs = 1; Rt = 3;
    #2 chk("prio_a", FwdA, 2'b01); chk("use_gate_b", FwdB, 2'b00);
    step(1);
    clear(); M_Wreg = 1; M_Rd = 9; Rs = 9; Use_Rs = 1;
    #2 chk("mem_fwd_a", FwdA, 2'b10);
    step(1);

    // Redirect beats a simultaneous load-use; in FLUSH, load-use is suppressed.
    load_r8(); Pcsrc = 2'b01;
    #2 chk("rd_ifid", IFID_Flush, 1'b1); chk("rd_idex", IDEX_Flush, 1'b1); chk("rd_pc", PC_En, 1'b1);
    step(1); chk("rd_state", State, 2'b10);
    Pcsrc = 2'b00;
    #2 chk("fl_pc", PC_En, 1'b1); chk("fl_idex", IDEX_Flush, 1'b0);
    step(1); chk("fl_state", State, 2'b00);

    // A freeze holds a pending redirect, which is taken on the first non-busy cycle.
    clear(); Mem_Busy = 1; Pcsrc = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #2 chk("fz_pc", PC_En, 1'b0); chk("fz_ifid", IFID_Flush, 1'b0);
      step(1); chk("fz_state", State, 2'b11);
    end
    Mem_Busy = 0;
    #2 chk("fz_exit_flush", IFID_Flush, 1'b1);
    step(1); chk("fz_exit_state", State, 2'b10);

    // A freeze entered from FLUSH, then exited into a load-use stall.
    load_r8(); Mem_Busy = 1; step(1); chk("fz2_state", State, 2'b11);
    Mem_Busy = 0;
    #2 chk("fz2_idex", IDEX_Flush, 1'b1);
    step(1); chk("fz2_stall", State, 2'b01);

    // En=0 holds everything, including the State.
    clear(); En = 0; Pcsrc = 2'b01;
    #2 chk("hold_pc", PC_En, 1'b0); chk("hold_flush", IFID_Flush, 1'b0);
    step(2); chk("hold_state", State, 2'b01);
    clear(); step(1); chk("resume_state", State, 2'b00);

    // A write to register 0 is never a dependence.
    clear(); E_Wreg = 1; E_Mem2reg = 1; E_Rd = 0; Rs = 0; Use_Rs = 1;
    #2 chk("r0_fwd", FwdA, 2'b00); chk("r0_pc", PC_En, 1'b1);
    step(1);

    // Asynchronous reset while in STALL.
    load_r8(); step(1); chk("pre_rst_state", State, 2'b01);
    M_Wreg = 1; M_Rd = 8; Rs = 8; Use_Rs = 1;
    #3 Clrn = 0;
    #1 chk("arst_state", State, 2'b00); chk("arst_sc", Stall_Cnt, 16'd0);
    chk("arst_fc", Flush_Cnt, 16'd0); chk("arst_fwd", FwdA, 2'b00); chk("arst_pc", PC_En, 1'b1);
    step(1); Clrn = 1; clear();
    #2 chk("post_rst_idex", IDEX_Flush, 1'b0); chk("post_rst_pc", PC_En, 1'b1);
    step(1); chk("post_rst_state", State, 2'b00);

`ifdef HAZARD_STAT_EN
    // Drive the stall counter into saturation.
    for (int i = 0; i < 65540; i++) begin
      load_r8(); step(1); clear(); step(1);
    end
    chk("sat_stall", Stall_Cnt, 16'hFFFF);
`else
    for (int i = 0; i < 4; i++) begin
      load_r8(); step(1); clear(); step(1);
    end
    chk("nostat_stall", Stall_Cnt, 16'd0);
`endif

    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 Clrn  input  1  reset, asynchronous, active-low.
REQ-003 En  input  1  global pipeline enable; 0 = whole pipeline holds.
REQ-004 Rs, Rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 Use_Rs, Use_Rt  input  1 each  ID instruction actually reads Rs / Rt.
REQ-006 E_Rd  input  5  destination of the instruction in EX.
REQ-007 E_Wreg, E_Mem2reg  input  1 each  EX writes a register / EX is a load.
REQ-008 M_Rd  input  5  destination of the instruction in MEM.
REQ-009 M_Wreg  input  1  MEM writes a register.
REQ-010 Pcsrc  input  2  PC source resolved in EX; 00 = sequential, any other value = taken redirect.
REQ-011 Mem_Busy  input  1  data memory not ready this cycle.
REQ-012 PC_En, IFID_En  output  1 each  write enables of the PC and IF/ID registers.
REQ-013 IFID_Flush, IDEX_Flush  output  1 each  load a bubble into IF/ID / ID/EX.
REQ-014 FwdA, FwdB  output  2 each  operand source select: 00 register file, 01 EX result, 10 MEM result.
REQ-015 State  output  2  current controller state code.
REQ-016 Stall_Cnt, Flush_Cnt  output  16 each  statistics counters (see Configuration).

Function
REQ-017 States: RUN=00, STALL=01, FLUSH=10, FREEZE=11; State register updates on rising Clk only when En=1.
REQ-018 Control outputs are combinational in the current inputs and State; zero added latency.
REQ-019 EX match on Rs: E_Wreg=1, E_Rd!=0, E_Rd==Rs, Use_Rs=1; MEM match defined likewise with M_Wreg/M_Rd; same rules apply to Rt.
REQ-020 FwdA = 01 on EX match with E_Mem2reg=0; else 10 on MEM match; else 00; FwdB is identical on Rt; EX has priority over MEM.
REQ-021 Load-use hazard: EX match on Rs or Rt with E_Mem2reg=1.
REQ-022 Priority per cycle: En=0 > Mem_Busy > redirect > load-use hazard > normal.
REQ-023 En=0: PC_En=0, IFID_En=0, both flushes 0; State holds.
REQ-024 Mem_Busy=1 (En=1): PC_En=0, IFID_En=0, both flushes 0; next State=FREEZE; a pending redirect or hazard is acted on in the first cycle with Mem_Busy=0.
REQ-025 Redirect (Pcsrc!=00, no freeze): PC_En=1, IFID_En=1, IFID_Flush=1, IDEX_Flush=1; next State=FLUSH.
REQ-026 Load-use (no freeze, no redirect, State!=FLUSH): PC_En=0, IFID_En=0, IDEX_Flush=1, IFID_Flush=0; next State=STALL.
REQ-027 In State=FLUSH, load-use detection is suppressed (ID holds a bubble); forwarding is still computed.
REQ-028 A stall lasts exactly one cycle per load: in State=STALL, a repeated match no longer counts (the load has moved to MEM); forwarding then selects 10.
REQ-029 Normal cycle: PC_En=1, IFID_En=1, flushes 0; next State=RUN.
REQ-030 FREEZE exit: next State chosen by REQ-025..029 evaluated in the first non-busy cycle.

Reset
REQ-031 Clrn=0 asynchronously forces State=RUN and Stall_Cnt=Flush_Cnt=0, independent of Clk and En.
REQ-032 During reset, outputs are PC_En=1, IFID_En=1, flushes 0, FwdA=FwdB=00 (datapath held in reset separately).
REQ-033 Reset deasserted mid-stall or mid-flush resumes in RUN; no stale flush or stall is issued.

Configuration
REQ-034 With HAZARD_STAT_EN defined: Stall_Cnt increments on each clocked cycle with REQ-026 active, Flush_Cnt on each with REQ-025 active; both are 16-bit, saturate at 0xFFFF, and hold when En=0.
REQ-035 Without HAZARD_STAT_EN: ports remain, driven constant 0, and no counter flops are synthesised.

Verification
REQ-036 EX addi writes r5 (E_Wreg=1, E_Mem2reg=0, E_Rd=5); ID Rs=5 Use_Rs=1 -> FwdA=01, PC_En=1, State stays 00.
REQ-037 EX lw r8 (E_Mem2reg=1, E_Rd=8); ID Rt=8 Use_Rt=1 -> one cycle PC_En=0, IDEX_Flush=1, State=01; next cycle (M_Rd=8) FwdB=10, PC_En=1, State=00.
REQ-038 Pcsrc=01 together with load-use match -> IFID_Flush=IDEX_Flush=1, PC_En=1, State=10, Flush_Cnt+1, Stall_Cnt unchanged.
REQ-039 Mem_Busy=1 for 3 cycles while Pcsrc=10 -> PC_En=0, no flush, State=11; first cycle with Mem_Busy=0 -> redirect flush, State=10.
REQ-040 E_Rd=0 with E_Wreg=1, Rs=0 -> FwdA=00, no stall; Clrn pulsed low while State=01 -> State=00 immediately, counters 0.
REQ-041 HAZARD_STAT_EN defined, 65540 consecutive load-use stalls -> Stall_Cnt=0xFFFF; undefined -> Stall_Cnt=0 throughout.
